ifid_ctl: RTL

Fetch-side responder to the load-use hazard detector. Owns the PC and the IF/ID pipeline register, and obeys the detector's `stall` request by holding fetch. It also flushes IF/ID on a taken jump and tells the ID/EX register when to capture a bubble. It sits between the instruction memory (asynchronous read) and the decode stage feeding the hazard detector.

---
 rtl/ifid_ctl_pkg.sv | 24 ++
 rtl/ifid_ctl_sat_counter16.sv | 19 +
 rtl/ifid_ctl.sv | 103 ++++++++++
 3 files changed

// File: rtl/ifid_ctl_pkg.sv
// Shared encodings for the fetch/IF-ID control slice: NOP word, FSM states, opcodes.
package ifid_ctl_pkg;

   localparam logic [15:0] INSTR_NOP = 16'h0000;

   typedef enum logic [1:0] {
      IFID_BOOT  = 2'd0,
      IFID_RUN   = 2'd1,
      IFID_HOLD  = 2'd2,
      IFID_FLUSH = 2'd3
   } ifid_state_t;

   // Instruction layout: opcode [15:10], rs [9:5], rt [4:0].
   typedef enum logic [5:0] {
      OP_NOP = 6'h00,
      OP_ADD = 6'h01,
      OP_SUB = 6'h02,
      OP_LW  = 6'h08,
      OP_SW  = 6'h09,
      OP_BEQ = 6'h10,
      OP_J   = 6'h11
   } opcode_t;

endpackage

// File: rtl/ifid_ctl_sat_counter16.sv
// 16-bit saturating event counter with async clear; built only when IFID_PERF_EN is defined.
`ifdef IFID_PERF_EN
module sat_counter16 (
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   output logic [15:0] count
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         count <= 16'h0000;
      end else if (en && (count != 16'hFFFF)) begin
         count <= count + 16'h0001;
      end
   end

endmodule
`endif

// File: rtl/ifid_ctl.sv
// PC + IF/ID register owner: obeys load-use stalls, flushes on taken jumps.
// Optional perf counters are built under the IFID_PERF_EN macro.
module ifid_ctl
   import ifid_ctl_pkg::*;
#(
   parameter int              PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              MAX_STALL = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_data,
   output logic [15:0]     id_instr,
   output logic [PC_W-1:0] id_pc,
   output logic            id_valid,
   output logic            ex_nop,
   output logic            stall_err,
   output logic [15:0]     perf_stalls,
   output logic [15:0]     perf_flushes
);

   localparam int             CNT_W     = $clog2(MAX_STALL + 2);
   localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_STALL + 1);

   logic [PC_W-1:0]  pc;
   ifid_state_t      state;
   logic [CNT_W-1:0] run_cnt;
   logic             stall_eff;

   // A bubble in ID can alias rs/rt against EX, so its stall request is ignored.
   assign stall_eff = stall & id_valid & ~redirect;
   assign ex_nop    = stall_eff | ~id_valid;
   assign imem_addr = pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc       <= RESET_PC;
         id_instr <= INSTR_NOP;
         id_pc    <= '0;
         id_valid <= 1'b0;
         state    <= IFID_BOOT;
      end else begin
         unique case (state)
            IFID_BOOT, IFID_FLUSH: state <= redirect ? IFID_FLUSH : IFID_RUN;
            IFID_RUN, IFID_HOLD:   state <= redirect  ? IFID_FLUSH :
                                            stall_eff ? IFID_HOLD  : IFID_RUN;
            default:               state <= IFID_BOOT;
         endcase

         if (redirect) begin
            pc       <= redirect_pc;
            id_instr <= INSTR_NOP;
            id_valid <= 1'b0;
         end else if (!stall_eff) begin
            pc       <= pc + 1'b1;
            id_instr <= imem_data;
            id_pc    <= pc;
            id_valid <= 1'b1;
         end
      end
   end

   // Consecutive-stall watchdog; saturates so stall_err remains the only sticky record.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt   <= '0;
         stall_err <= 1'b0;
      end else begin
         if (!stall_eff) begin
            run_cnt <= '0;
         end else if (run_cnt != RUN_LIMIT) begin
            run_cnt <= run_cnt + 1'b1;
         end
         if (stall_eff && (run_cnt == RUN_LIMIT - 1'b1)) begin
            stall_err <= 1'b1;
         end
      end
   end

`ifdef IFID_PERF_EN
   sat_counter16 u_perf_stalls (
      .clk   (clk),
      .clr   (rst),
      .en    (stall_eff),
      .count (perf_stalls)
   );

   sat_counter16 u_perf_flushes (
      .clk   (clk),
      .clr   (rst),
      .en    (redirect),
      .count (perf_flushes)
   );
`else
   assign perf_stalls  = 16'h0000;
   assign perf_flushes = 16'h0000;
`endif

endmodule
